screen_painter: RTL and testbench
=================================

// Module: screen_painter
// PURPOSE
//  Parametrised full-screen paint engine feeding the VGA adapter's x/y/colour/plot inputs.
//  On a start pulse it sweeps every pixel of a SCREEN_W x SCREEN_H frame exactly once.
//  Each pixel is painted from a solid colour, a selected image ROM, or a colour-keyed image.
//  Used for title, game-over, flash and clear screens; signals completion with a done pulse.
// PARAMETERS
//  SCREEN_W  160  pixels per row
//  SCREEN_H  120  rows per frame
//  COLOUR_W  3    bits per pixel colour
//  X_W       8    x coordinate width, must satisfy 2**X_W >= SCREEN_W
//  Y_W       7    y coordinate width, must satisfy 2**Y_W >= SCREEN_H
//  ADDR_W    15   ROM address width, must satisfy 2**ADDR_W >= SCREEN_W*SCREEN_H
//  NUM_IMG   2    number of image ROMs muxed onto rom_data
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous active-low reset
//  start        in   1            1-cycle request; honoured only in IDLE
//  abort        in   1            cancel the sweep in progress; no done pulse follows
//  mode         in   2            0 SOLID, 1 IMAGE, 2 KEYED, 3 INVERT (latched at start)
//  img_sel      in   $clog2(NUM_IMG)  image index (latched at start)
//  fill_colour  in   COLOUR_W     SOLID colour (latched at start)
//  key_colour   in   COLOUR_W     KEYED match colour (latched at start)
//  sub_colour   in   COLOUR_W     KEYED replacement colour (latched at start)
//  rom_addr     out  ADDR_W       linear pixel address = y*SCREEN_W + x
//  rom_sel      out  $clog2(NUM_IMG)  latched img_sel, drives the ROM mux
//  rom_data     in   COLOUR_W     ROM word; valid exactly 1 cycle after rom_addr
//  x            out  X_W          pixel column, aligned with plot
//  y            out  Y_W          pixel row, aligned with plot
//  colour       out  COLOUR_W     pixel colour, aligned with plot
//  plot         out  1            write strobe for the VGA adapter
//  busy         out  1            high from the cycle after start until done
//  done         out  1            1-cycle pulse after the last plot
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//   - state goes to IDLE.
//   - All outputs are 0: rom_addr, x, y, colour, plot, busy, done.
//   - Reset overrides start and abort in the same cycle, including mid-sweep.
//  States and transitions:
//   - IDLE: on start=1, latch mode, img_sel and colours, clear counters, go to SWEEP.
//   - SWEEP: each cycle issue one address, then advance the counters.
//     - Counters are x_cnt, y_cnt and a linear addr_cnt; no divide or modulo.
//     - When x_cnt==SCREEN_W-1: x_cnt<=0 and y_cnt++.
//     - After issuing addr SCREEN_W*SCREEN_H-1, go to FLUSH.
//   - FLUSH: one cycle that retires the final pixel, then go to DONE.
//   - DONE: done=1 for one cycle, busy=0, return to IDLE.
//     - start may be accepted again in the following cycle.
//  Pipeline:
//   - Stage 0 issues rom_addr and the stage-0 x/y.
//   - Stage 1 registers x/y/plot and computes colour from rom_data.
//   - First plot occurs 2 cycles after the cycle in which start is sampled.
//   - One pixel per cycle, no gaps.
//   - Exactly SCREEN_W*SCREEN_H plot cycles per sweep.
//  Colour select at stage 1:
//   - SOLID: fill_colour; ROM ignored.
//   - IMAGE: rom_data.
//   - KEYED: (rom_data==key_colour) ? sub_colour : rom_data.
//   - INVERT: ~rom_data.
//  Boundary rules:
//   - start while busy or in DONE: ignored, with no effect on latched settings.
//   - abort in SWEEP/FLUSH: next cycle state=IDLE, plot=0, busy=0, no done pulse.
//   - abort in IDLE: no effect.
//   - start and abort together in IDLE: start wins.
//   - Input changes mid-sweep do not affect the frame, because settings are latched.
//   - Coordinates never exceed SCREEN_W-1 / SCREEN_H-1, and rom_addr never exceeds W*H-1.
//   - The last pixel plotted is (SCREEN_W-1, SCREEN_H-1).
// STRUCTURE
//  - Shared package snake_gfx_pkg holds: mode encodings (MODE_SOLID..MODE_INVERT),
//    default screen dimensions, and colour constants (BLACK=3'b000, RED=3'b100).
//  - Sub-module screen_scan_counter holds the x/y/linear-address counters with wrap
//    and a last flag; it is reusable by the sprite and grid drawers.
//  - The FSM and colour-select stage stay in screen_painter.
//  - Image ROMs are instantiated outside and muxed by rom_sel.
// TESTING
//  The bench uses W=4, H=3, COLOUR_W=3 and a behavioural 1-cycle ROM for directed cases;
//  default parameters are used for one full-frame run.
//  - SOLID, fill=3'b010, start at cycle 0 ->
//    12 plots at cycles 2..13 in order (0,0),(1,0)..(3,2), all colour 010; done at 15.
//  - IMAGE, ROM[a]=a%8 ->
//    colour at address a equals a%8; rom_addr 0..11 monotonic; x/y consistent with a=y*4+x.
//  - KEYED, key=100, sub=000, ROM has 100 at addr 5 ->
//    pixel (1,1)=000; all other pixels pass the ROM value through.
//  - abort at plot 6 ->
//    plot=0 and busy=0 on the next cycle; no done pulse; a restart then yields a full 12 plots.
//  - start pulsed mid-sweep, and start together with abort in IDLE ->
//    the mid-sweep start is ignored (frame unchanged, single done);
//    start+abort in IDLE begins a sweep.
//  - rst low at plot 4 ->
//    all outputs are 0 the next cycle; with defaults 160x120 a full sweep gives
//    19200 plots and a last address of 19199.

Source files
------------

// File: rtl/snake_gfx_pkg.sv
// Shared graphics definitions for the snake game drawers: paint modes,
// default screen geometry and common colours.
package snake_gfx_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'd0,
        MODE_IMAGE  = 2'd1,
        MODE_KEYED  = 2'd2,
        MODE_INVERT = 2'd3
    } paint_mode_e;

    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;
    localparam int unsigned DEF_COLOUR_W = 3;
    localparam int unsigned DEF_X_W      = 8;
    localparam int unsigned DEF_Y_W      = 7;
    localparam int unsigned DEF_ADDR_W   = 15;
    localparam int unsigned DEF_NUM_IMG  = 2;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;

endpackage

// File: rtl/screen_scan_counter.sv
// Raster scan counter: x/y plus a linear address kept in step without division,
// with a registered flag marking the final pixel of the frame.
module screen_scan_counter #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [X_W-1:0]    x_o,
    output logic [Y_W-1:0]    y_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;

    // Clear wins over advance; the address wraps together with the raster.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        last_d = last_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            last_d = (X_LAST == '0) && (Y_LAST == '0);
        end else if (advance_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
            addr_d = last_q ? '0 : addr_q + ADDR_W'(1);
            last_d = (x_d == X_LAST) && (y_d == Y_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            last_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
            last_q <= last_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign addr_o = addr_q;
    assign last_o = last_q;

endmodule

// File: rtl/screen_painter.sv
// Full-screen paint engine: sweeps every pixel once per start, painting from a
// solid colour, an image ROM, a colour-keyed image or an inverted image.
module screen_painter
    import snake_gfx_pkg::*;
#(
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H,
    parameter int unsigned COLOUR_W = DEF_COLOUR_W,
    parameter int unsigned X_W      = DEF_X_W,
    parameter int unsigned Y_W      = DEF_Y_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_IMG  = DEF_NUM_IMG
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 mode,
    input  logic [$clog2(NUM_IMG)-1:0] img_sel,
    input  logic [COLOUR_W-1:0]        fill_colour,
    input  logic [COLOUR_W-1:0]        key_colour,
    input  logic [COLOUR_W-1:0]        sub_colour,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic [$clog2(NUM_IMG)-1:0] rom_sel,
    input  logic [COLOUR_W-1:0]        rom_data,
    output logic [X_W-1:0]             x,
    output logic [Y_W-1:0]             y,
    output logic [COLOUR_W-1:0]        colour,
    output logic                       plot,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned SEL_W = $clog2(NUM_IMG);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                v0_q, v0_d;
    logic                vm_q, vm_d;
    logic [X_W-1:0]      xm_q;
    logic [Y_W-1:0]      ym_q;
    paint_mode_e         mode_q, mode_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [COLOUR_W-1:0] fill_q, fill_d, key_q, key_d, sub_q, sub_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d, pix;
    logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic                clear, advance, kill;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic                last0;

    screen_scan_counter #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .ADDR_W  (ADDR_W)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (clear),
        .advance_i(advance),
        .x_o      (x0),
        .y_o      (y0),
        .addr_o   (rom_addr),
        .last_o   (last0)
    );

    // Colour for the pixel whose ROM word is on rom_data this cycle.
    always_comb begin
        pix = rom_data;
        case (mode_q)
            MODE_SOLID: pix = fill_q;
            MODE_IMAGE: pix = rom_data;
            MODE_KEYED: pix = (rom_data == key_q) ? sub_q : rom_data;
            default:    pix = ~rom_data;
        endcase
    end

    // Sweep control; SWEEP holds one extra cycle after the last issue so that
    // FLUSH coincides with the final plot.
    always_comb begin
        state_d  = state_q;
        v0_d     = v0_q;
        vm_d     = 1'b0;
        clear    = 1'b0;
        advance  = 1'b0;
        mode_d   = mode_q;
        sel_d    = sel_q;
        fill_d   = fill_q;
        key_d    = key_q;
        sub_d    = sub_q;
        kill     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    clear   = 1'b1;
                    v0_d    = 1'b1;
                    mode_d  = paint_mode_e'(mode);
                    sel_d   = img_sel;
                    fill_d  = fill_colour;
                    key_d   = key_colour;
                    sub_d   = sub_colour;
                end
            end
            ST_SWEEP: begin
                vm_d = v0_q;
                if (v0_q) begin
                    if (last0) v0_d = 1'b0;
                    else       advance = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort && (state_q == ST_SWEEP || state_q == ST_FLUSH)) begin
            kill    = 1'b1;
            state_d = ST_IDLE;
            v0_d    = 1'b0;
            vm_d    = 1'b0;
            advance = 1'b0;
        end
        plot_d   = vm_q && !kill;
        x_d      = plot_d ? xm_q : '0;
        y_d      = plot_d ? ym_q : '0;
        colour_d = plot_d ? pix : '0;
        busy_d   = (state_d == ST_SWEEP) || (state_d == ST_FLUSH);
        done_d   = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            v0_q     <= 1'b0;
            vm_q     <= 1'b0;
            xm_q     <= '0;
            ym_q     <= '0;
            mode_q   <= MODE_SOLID;
            sel_q    <= '0;
            fill_q   <= '0;
            key_q    <= '0;
            sub_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            v0_q     <= v0_d;
            vm_q     <= vm_d;
            xm_q     <= x0;
            ym_q     <= y0;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            fill_q   <= fill_d;
            key_q    <= key_d;
            sub_q    <= sub_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign rom_sel = sel_q;
    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_screen_painter.sv
// Bench for screen_painter: a 4x3 instance for directed/random frames against a
// behavioural pixel model, and a default 160x120 instance for one full frame.
module tb_screen_painter;

    localparam int NS   = 12;
    localparam int NBIG = 19200;

    logic clk;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic       s_rst, s_start, s_abort, s_sel, s_rom_sel, s_plot, s_busy, s_done;
    logic [1:0] s_mode, s_x, s_y;
    logic [2:0] s_fill, s_key, s_sub, s_rom_data, s_colour;
    logic [3:0] s_rom_addr;
    logic [2:0] s_rom [2][16];

    logic        f_rst, f_start, f_abort, f_sel, f_rom_sel, f_plot, f_busy, f_done;
    logic [1:0]  f_mode;
    logic [2:0]  f_fill, f_key, f_sub, f_rom_data, f_colour;
    logic [14:0] f_rom_addr;
    logic [7:0]  f_x;
    logic [6:0]  f_y;

    screen_painter #(
        .SCREEN_W(4), .SCREEN_H(3), .COLOUR_W(3), .X_W(2), .Y_W(2), .ADDR_W(4), .NUM_IMG(2)
    ) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .abort(s_abort), .mode(s_mode),
        .img_sel(s_sel), .fill_colour(s_fill), .key_colour(s_key), .sub_colour(s_sub),
        .rom_addr(s_rom_addr), .rom_sel(s_rom_sel), .rom_data(s_rom_data),
        .x(s_x), .y(s_y), .colour(s_colour), .plot(s_plot), .busy(s_busy), .done(s_done)
    );

    screen_painter u_full (
        .clk(clk), .rst(f_rst), .start(f_start), .abort(f_abort), .mode(f_mode),
        .img_sel(f_sel), .fill_colour(f_fill), .key_colour(f_key), .sub_colour(f_sub),
        .rom_addr(f_rom_addr), .rom_sel(f_rom_sel), .rom_data(f_rom_data),
        .x(f_x), .y(f_y), .colour(f_colour), .plot(f_plot), .busy(f_busy), .done(f_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency image ROMs.
    always @(posedge clk) begin
        s_rom_data <= s_rom[s_rom_sel][s_rom_addr];
        f_rom_data <= f_rom_addr[2:0] ^ (f_rom_sel ? 3'b111 : 3'b000);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_colour(input logic [1:0] m, input int sel,
                                              input logic [2:0] f, input logic [2:0] k,
                                              input logic [2:0] sb, input int a);
        logic [2:0] r;
        r = s_rom[sel][a];
        case (m)
            2'd0:    return f;
            2'd1:    return r;
            2'd2:    return (r == k) ? sb : r;
            default: return ~r;
        endcase
    endfunction

    // Run one 4x3 frame; optional stray starts mid-sweep and in DONE, optional abort with start.
    task automatic frame_small(input string tag, input logic [1:0] m, input logic sel,
                               input logic [2:0] f, input logic [2:0] k, input logic [2:0] sb,
                               input int mid_start, input logic with_abort);
        int nplot = 0;
        int ndone = 0;
        s_mode = m; s_sel = sel; s_fill = f; s_key = k; s_sub = sb;
        s_start = 1'b1; s_abort = with_abort;
        tick();
        s_start = 1'b0; s_abort = 1'b0;
        for (int c = 0; c <= 18; c++) begin
            if (c <= 11) check({tag, "_addr"}, s_rom_addr, c);
            if (c == 1 || c == 13) check({tag, "_busy"}, s_busy, 1);
            if (c == 15) check({tag, "_busy_at_done"}, s_busy, 0);
            if (s_plot) begin
                check({tag, "_plot_cycle"}, c, nplot + 2);
                if (nplot < NS) begin
                    check({tag, "_x"}, s_x, nplot % 4);
                    check({tag, "_y"}, s_y, nplot / 4);
                    check({tag, "_colour"}, s_colour, exp_colour(m, sel, f, k, sb, nplot));
                end
                nplot++;
            end
            if (s_done) begin
                check({tag, "_done_cycle"}, c, 15);
                ndone++;
            end
            s_start = (mid_start >= 0) && (c == mid_start || c == 14);
            s_mode = 2'($urandom); s_sel = 1'($urandom);
            s_fill = 3'($urandom); s_key = 3'($urandom); s_sub = 3'($urandom);
            tick();
        end
        s_start = 1'b0;
        check({tag, "_nplots"}, nplot, NS);
        check({tag, "_ndone"}, ndone, 1);
    endtask

    initial begin
        int cnt, nplot, ndone, done_c, maxaddr, lastx, lasty;
        s_rst = 0; s_start = 0; s_abort = 0; s_mode = 0; s_sel = 0;
        s_fill = 0; s_key = 0; s_sub = 0;
        f_rst = 0; f_start = 0; f_abort = 0; f_mode = 0; f_sel = 0;
        f_fill = 0; f_key = 0; f_sub = 0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 16; a++) s_rom[i][a] = 3'($urandom);
        tick(); tick();
        check("rst_addr", s_rom_addr, 0);
        check("rst_plot", s_plot, 0);
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_xy", {s_x, s_y, s_colour}, 0);
        check("rst_full_busy", {f_plot, f_busy, f_done}, 0);
        s_rst = 1; f_rst = 1;
        tick();

        frame_small("solid", 2'd0, 1'b0, 3'b010, 3'b000, 3'b000, -1, 1'b0);

        for (int a = 0; a < 16; a++) s_rom[1][a] = 3'(a % 8);
        frame_small("image", 2'd1, 1'b1, 3'b000, 3'b000, 3'b000, -1, 1'b0);

        for (int a = 0; a < 16; a++) begin
            s_rom[0][a] = 3'($urandom);
            if (s_rom[0][a] == 3'b100) s_rom[0][a] = 3'b011;
        end
        s_rom[0][5] = 3'b100;
        frame_small("keyed", 2'd2, 1'b0, 3'b111, 3'b100, 3'b000, -1, 1'b0);

        frame_small("invert", 2'd3, 1'b1, 3'b000, 3'b000, 3'b000, -1, 1'b0);
        frame_small("midstart", 2'd2, 1'b1, 3'b001, 3'b010, 3'b101, 5, 1'b0);
        frame_small("start_abort", 2'd1, 1'b0, 3'b000, 3'b000, 3'b000, -1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 2; i++)
                for (int a = 0; a < 16; a++) s_rom[i][a] = 3'($urandom);
            frame_small("random", 2'($urandom_range(0, 3)), 1'($urandom), 3'($urandom),
                        3'($urandom), 3'($urandom), (r % 2 == 0) ? int'($urandom_range(1, 10)) : -1,
                        1'($urandom));
        end

        // Abort while pixel 6 is being plotted.
        s_mode = 2'd1; s_sel = 1'b0; s_start = 1; tick(); s_start = 0;
        repeat (8) tick();
        check("abort_pre_plot", s_plot, 1);
        check("abort_pre_x", s_x, 2);
        s_abort = 1; tick(); s_abort = 0;
        check("abort_plot", s_plot, 0);
        check("abort_busy", s_busy, 0);
        cnt = 0;
        repeat (10) begin
            if (s_done || s_plot || s_busy) cnt++;
            tick();
        end
        check("abort_quiet", cnt, 0);
        frame_small("restart", 2'd1, 1'b0, 3'b000, 3'b000, 3'b000, -1, 1'b0);

        s_abort = 1; tick(); s_abort = 0;
        check("idle_abort_busy", s_busy, 0);
        tick();
        check("idle_abort_plot", {s_plot, s_busy, s_done}, 0);

        // Reset while pixel 4 is being plotted, with start held.
        s_mode = 2'd3; s_start = 1; tick(); s_start = 0;
        repeat (6) tick();
        check("rstmid_pre_plot", s_plot, 1);
        s_rst = 0; s_start = 1; s_abort = 1; tick();
        check("rstmid_addr", s_rom_addr, 0);
        check("rstmid_xyc", {s_x, s_y, s_colour}, 0);
        check("rstmid_flags", {s_plot, s_busy, s_done}, 0);
        s_start = 0; s_abort = 0; s_rst = 1;
        cnt = 0;
        repeat (20) begin
            if (s_done || s_plot || s_busy) cnt++;
            tick();
        end
        check("rstmid_quiet", cnt, 0);

        // Full default-size frame from image 0 (word = address mod 8).
        f_mode = 2'd1; f_sel = 1'b0; f_start = 1; tick(); f_start = 0;
        nplot = 0; ndone = 0; done_c = -1; maxaddr = 0; lastx = -1; lasty = -1;
        for (int c = 0; c < NBIG + 8; c++) begin
            if (c < NBIG) check("big_addr", f_rom_addr, c);
            if (int'(f_rom_addr) > maxaddr) maxaddr = int'(f_rom_addr);
            if (f_plot) begin
                check("big_x", f_x, nplot % 160);
                check("big_y", f_y, nplot / 160);
                check("big_colour", f_colour, nplot % 8);
                lastx = int'(f_x); lasty = int'(f_y);
                nplot++;
            end
            if (f_done) begin
                ndone++;
                done_c = c;
            end
            f_mode = 2'($urandom); f_sel = 1'($urandom); f_fill = 3'($urandom);
            tick();
        end
        check("big_nplots", nplot, NBIG);
        check("big_max_addr", maxaddr, NBIG - 1);
        check("big_last_xy", {16'(lastx), 16'(lasty)}, {16'd159, 16'd119});
        check("big_ndone", ndone, 1);
        check("big_done_cycle", done_c, NBIG + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
